load_store_unit: RTL and testbench

Load/store unit between the execute stage and the word-organised data memory. Accepts one byte/halfword/word load or store request at a time, checks alignment and range, converts byte addresses to word indices, sign/zero-extends loads, and performs read-modify-write for sub-word stores because the memory has no byte enables. Drives the memory's `addr`/`dataIn`/`memoryEnable`/`readNotWrite` and consumes its registered `dataOut`.

---
 rtl/load_store_unit.sv | 211 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
// Load/store unit between the execute stage and a word-organised data memory.
// Handles one byte/halfword/word request at a time, checks alignment and
// range, converts byte addresses to word indices, sign/zero-extends loads and
// does read-modify-write for sub-word stores (the memory has no byte enables).
//
// Optional feature: define LSU_SUBWORD_EN to enable byte/halfword accesses.
// Without it every non-word size faults and the lane merge path is removed.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o  request handshake (accept on valid & ready)
//   req_write_i              1 store, 0 load
//   req_size_i               00 byte, 01 half, 10 word, 11 illegal
//   req_signed_i             sign-extend sub-word loads
//   req_addr_i, req_wdata_i  byte address, store data
//   resp_valid_o/resp_ready_i response handshake, held until accepted
//   resp_rdata_o             extended load data, 0 for stores/faults
//   resp_fault_o             misaligned, out of range or illegal size
//   mem_addr_o, mem_wdata_o  word index and write word
//   mem_rdata_i              registered memory read data
//   mem_enable_o             read enable
//   mem_read_not_write_o     0 writes memory on that rising edge
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_fault_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_enable_o,
    output logic        mem_read_not_write_o
);

    // state | meaning
    // IDLE  | ready for a request
    // READ  | memory read cycle at the latched word index
    // DATA  | memory data valid: extend load or merge sub-word store
    // WRITE | memory write cycle (read_not_write low)
    // RESP  | response held until resp_ready_i
    typedef enum logic [2:0] {IDLE, READ, DATA, WRITE, RESP} state_e;

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    state_e      state_q, state_d;
    logic        accept;
    logic        fault_c;
    logic        size_bad;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] resp_rdata_q;
    logic        resp_fault_q;
    logic [31:0] load_data;

`ifdef LSU_SUBWORD_EN
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] merged;
`else
    logic        unused_req_signed;
    assign unused_req_signed = req_signed_i;
`endif

    assign accept = req_valid_i & (state_q == IDLE);

`ifdef LSU_SUBWORD_EN
    assign size_bad = (req_size_i == 2'b11)
                    | ((req_size_i == 2'b01) & req_addr_i[0])
                    | ((req_size_i == 2'b10) & (req_addr_i[1:0] != 2'b00));
`else
    assign size_bad = (req_size_i != 2'b10) | (req_addr_i[1:0] != 2'b00);
`endif
    assign fault_c = size_bad | (req_addr_i >= ADDR_LIMIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d              = state_q;
        req_ready_o          = 1'b0;
        resp_valid_o         = 1'b0;
        mem_enable_o         = 1'b0;
        mem_read_not_write_o = 1'b1;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (fault_c)
                        state_d = RESP;
`ifdef LSU_SUBWORD_EN
                    else if (req_write_i && req_size_i == 2'b10)
`else
                    else if (req_write_i)
`endif
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                mem_enable_o = 1'b1;
                state_d      = DATA;
            end
            DATA: begin
`ifdef LSU_SUBWORD_EN
                state_d = write_q ? WRITE : RESP;
`else
                state_d = RESP;
`endif
            end
            WRITE: begin
                mem_read_not_write_o = 1'b0;
                state_d              = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef LSU_SUBWORD_EN
    always_comb begin
        byte_sel = mem_rdata_i[7:0];
        case (lane_q)
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            2'd3:    byte_sel = mem_rdata_i[31:24];
            default: byte_sel = mem_rdata_i[7:0];
        endcase
        half_sel = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_q)
            2'b00:   load_data = signed_q ? {{24{byte_sel[7]}}, byte_sel}
                                          : {24'h0, byte_sel};
            2'b01:   load_data = signed_q ? {{16{half_sel[15]}}, half_sel}
                                          : {16'h0, half_sel};
            default: load_data = mem_rdata_i;
        endcase
    end

    // Store data sits in mem_wdata_q from accept until the merge replaces it.
    always_comb begin
        merged = mem_rdata_i;
        case (size_q)
            2'b00:   merged[{lane_q, 3'b000} +: 8]      = mem_wdata_q[7:0];
            2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = mem_wdata_q[15:0];
            default: merged = mem_rdata_i;
        endcase
    end
`else
    assign load_data = mem_rdata_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
`ifdef LSU_SUBWORD_EN
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            lane_q       <= 2'b00;
`endif
        end else if (accept) begin
            mem_addr_q   <= {2'b00, req_addr_i[31:2]};
            mem_wdata_q  <= req_wdata_i;
            resp_rdata_q <= '0;
            resp_fault_q <= fault_c;
`ifdef LSU_SUBWORD_EN
            write_q      <= req_write_i;
            size_q       <= req_size_i;
            signed_q     <= req_signed_i;
            lane_q       <= req_addr_i[1:0];
`endif
        end else if (state_q == DATA) begin
`ifdef LSU_SUBWORD_EN
            if (write_q) mem_wdata_q  <= merged;
            else         resp_rdata_q <= load_data;
`else
            resp_rdata_q <= load_data;
`endif
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_fault_o = resp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_enable;
    logic        mem_rnw;

    int checks   = 0;
    int failures = 0;
    int write_edges = 0;

    logic [31:0] mem [0:255];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [31:0] bd_data;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_size_i(req_size),
        .req_signed_i(req_signed), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_fault_o(resp_fault),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_enable_o(mem_enable),
        .mem_read_not_write_o(mem_rnw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: writes whenever read_not_write is low, registered dataOut.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (!mem_rnw) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            write_edges <= write_edges + 1;
        end
        if (mem_enable) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = idx; bd_data = val;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd,
                          output logic flt, output int wr);
        int w0;
        w0 = write_edges;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w; req_size = 2'b11; req_signed = ~sg;
        req_addr = 32'hFFFF_FFFF; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd  = resp_rdata;
        flt = resp_fault;
        wr  = write_edges - w0;
        if (resp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
        checks++; if (resp_fault !== 1'b0) begin failures++; $display("FAIL rst_resp_fault got=%b exp=0", resp_fault); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (mem_enable !== 1'b0) begin failures++; $display("FAIL rst_mem_enable got=%b exp=0", mem_enable); end
        checks++; if (mem_rnw !== 1'b1) begin failures++; $display("FAIL rst_mem_rnw got=%b exp=1", mem_rnw); end
    endtask

    task automatic test_word();
        int lat, wr; logic [31:0] rd; logic flt;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, flt, wr);
        checks++; if (lat !== 2) begin failures++; $display("FAIL wst_lat got=%0d exp=2", lat); end
        checks++; if (wr !== 1) begin failures++; $display("FAIL wst_writes got=%0d exp=1", wr); end
        checks++; if (flt !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL wst_resp got=%b/%h exp=0/0", flt, rd); end
        checks++; if (mem_addr !== 32'd4) begin failures++; $display("FAIL wst_mem_addr got=%h exp=4", mem_addr); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL wst_mem got=%h exp=deadbeef", mem[4]); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, flt, wr);
        checks++; if (lat !== 3) begin failures++; $display("FAIL wld_lat got=%0d exp=3", lat); end
        checks++; if (rd !== 32'hDEADBEEF || flt !== 1'b0) begin failures++; $display("FAIL wld_data got=%h/%b exp=deadbeef/0", rd, flt); end
        checks++; if (wr !== 0) begin failures++; $display("FAIL wld_writes got=%0d exp=0", wr); end
        preload(8'd255, 32'hCAFEF00D);
        do_req(1'b0, 2'b10, 1'b1, 32'h3FC, 32'h0, lat, rd, flt, wr);
        checks++; if (rd !== 32'hCAFEF00D || flt !== 1'b0) begin failures++; $display("FAIL wld_top got=%h/%b exp=cafef00d/0", rd, flt); end
    endtask

`ifdef LSU_SUBWORD_EN
    task automatic test_subword();
        int lat, wr; logic [31:0] rd; logic flt;
        preload(8'd4, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA, lat, rd, flt, wr);
        checks++; if (lat !== 4) begin failures++; $display("FAIL bst_lat got=%0d exp=4", lat); end
        checks++; if (wr !== 1) begin failures++; $display("FAIL bst_writes got=%0d exp=1", wr); end
        checks++; if (mem[4] !== 32'h1122AA44) begin failures++; $display("FAIL bst_mem got=%h exp=1122aa44", mem[4]); end
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, rd, flt, wr);
        checks++; if (rd !== 32'hFFFFFFAA || lat !== 3) begin failures++; $display("FAIL bld_signed got=%h lat=%0d exp=ffffffaa lat=3", rd, lat); end
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rd, flt, wr);
        checks++; if (rd !== 32'h000000AA) begin failures++; $display("FAIL bld_unsigned got=%h exp=000000aa", rd); end
        preload(8'd4, 32'h80015566);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, flt, wr);
        checks++; if (rd !== 32'hFFFF8001 || flt !== 1'b0) begin failures++; $display("FAIL hld_signed got=%h/%b exp=ffff8001/0", rd, flt); end
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, rd, flt, wr);
        checks++; if (rd !== 32'h00005566) begin failures++; $display("FAIL hld_low got=%h exp=00005566", rd); end
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFFBEEF, lat, rd, flt, wr);
        checks++; if (mem[4] !== 32'hBEEF5566 || wr !== 1) begin failures++; $display("FAIL hst_mem got=%h wr=%0d exp=beef5566 wr=1", mem[4], wr); end
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000007F, lat, rd, flt, wr);
        checks++; if (mem[4] !== 32'h7FEF5566) begin failures++; $display("FAIL bst_lane3 got=%h exp=7fef5566", mem[4]); end
    endtask
`else
    task automatic test_subword_off();
        int lat, wr; logic [31:0] rd; logic flt;
        do_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, lat, rd, flt, wr);
        checks++; if (flt !== 1'b1 || lat !== 1 || wr !== 0) begin failures++; $display("FAIL nosub_byte got=%b lat=%0d wr=%0d exp=1 lat=1 wr=0", flt, lat, wr); end
        do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'h0, lat, rd, flt, wr);
        checks++; if (flt !== 1'b1 || wr !== 0) begin failures++; $display("FAIL nosub_half got=%b wr=%0d exp=1 wr=0", flt, wr); end
    endtask
`endif

    task automatic test_faults();
        int lat, wr; logic [31:0] rd; logic flt;
        logic [1:0]  f_size [4];
        logic [31:0] f_addr [4];
        logic        f_wr   [4];
        f_size[0] = 2'b01; f_addr[0] = 32'h13;  f_wr[0] = 1'b0;
        f_size[1] = 2'b10; f_addr[1] = 32'h02;  f_wr[1] = 1'b1;
        f_size[2] = 2'b10; f_addr[2] = 32'h400; f_wr[2] = 1'b1;
        f_size[3] = 2'b11; f_addr[3] = 32'h0;   f_wr[3] = 1'b1;
        preload(8'd0, 32'h0BADF00D);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, rd, flt, wr);
            do_req(f_wr[i], f_size[i], 1'b1, f_addr[i], 32'h12345678, lat, rd, flt, wr);
            checks++; if (flt !== 1'b1) begin failures++; $display("FAIL fault_flag[%0d] got=%b exp=1", i, flt); end
            checks++; if (rd !== 32'h0) begin failures++; $display("FAIL fault_rdata[%0d] got=%h exp=0", i, rd); end
            checks++; if (lat !== 1) begin failures++; $display("FAIL fault_lat[%0d] got=%0d exp=1", i, lat); end
            checks++; if (wr !== 0) begin failures++; $display("FAIL fault_writes[%0d] got=%0d exp=0", i, wr); end
        end
        checks++; if (mem[0] !== 32'h0BADF00D) begin failures++; $display("FAIL fault_mem0 got=%h exp=0badf00d", mem[0]); end
    endtask

    task automatic test_back_pressure();
        int lat, wr; logic [31:0] rd; logic flt;
        preload(8'd4, 32'h0BADC0DE);
        resp_ready = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, flt, wr);
        checks++; if (rd !== 32'h0BADC0DE || lat !== 3) begin failures++; $display("FAIL bp_first got=%h lat=%0d exp=0badc0de lat=3", rd, lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BADC0DE || resp_fault !== 1'b0
                || req_ready !== 1'b0 || mem_rnw !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h f=%b rdy=%b rnw=%b exp 1/0badc0de/0/0/1",
                         i, resp_valid, resp_rdata, resp_fault, req_ready, mem_rnw);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_release got v=%b rdy=%b exp 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_reset_mid_write();
        int w0;
        preload(8'd6, 32'h55667788);
        w0 = write_edges;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_signed = 1'b0;
        req_addr = 32'h18; req_wdata = 32'h00000099;
`ifdef LSU_SUBWORD_EN
        req_size = 2'b00;
`else
        req_size = 2'b10;
`endif
        @(posedge clk); #1;
        req_valid = 1'b0;
`ifdef LSU_SUBWORD_EN
        repeat (2) begin @(posedge clk); #1; end
`endif
        checks++; if (mem_rnw !== 1'b0) begin failures++; $display("FAIL rmw_in_write got=%b exp=0", mem_rnw); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (mem_rnw !== 1'b1) begin failures++; $display("FAIL rmw_async_rnw got=%b exp=1", mem_rnw); end
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rmw_async_state got v=%b rdy=%b exp 0/1", resp_valid, req_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem[6] !== 32'h55667788) begin failures++; $display("FAIL rmw_mem got=%h exp=55667788", mem[6]); end
        checks++; if (write_edges !== w0) begin failures++; $display("FAIL rmw_writes got=%0d exp=%0d", write_edges, w0); end
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL rmw_after got rdy=%b v=%b exp 1/0", req_ready, resp_valid); end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        bd_we = 1'b0; bd_addr = 8'h0; bd_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_word();
`ifdef LSU_SUBWORD_EN
        test_subword();
`else
        test_subword_off();
`endif
        test_faults();
        test_back_pressure();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
